// File: rtl/timer_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the shared timer scheduler.
// Pure declarations: no latency, no flow control.
package timer_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int CNT_W_DEF = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after the pointer wins.
// Zero latency; no backpressure, the result is valid only while o_valid is high.
module rr_arbiter
  import timer_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_pointer,
  output logic [NREQ-1:0]  o_winner,
  output logic             o_valid
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Wrap the search position modulo NREQ without a divider.
      w_sum = {1'b0, i_pointer} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NREQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NREQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!o_valid && i_req[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        o_valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_timer_scheduler.sv
// One down-counter time-shared by NREQ requesters; grant one cycle after request, done N+1 cycles after.
// No queueing: requests are sampled only in IDLE, and the owner dropping req aborts its count.
module shared_timer_scheduler
  import timer_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] load_val,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [CNT_W-1:0]      remaining
);

  localparam int PTR_W = ptr_width(NREQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  state_t           r_state;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_owner;

  state_t           w_state_nxt;
  logic [NREQ-1:0]  w_grant_nxt;
  logic [NREQ-1:0]  w_done_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] w_owner_nxt;

  logic [NREQ-1:0]  w_win;
  logic             w_win_vld;
  logic [PTR_W-1:0] w_win_idx;
  logic [CNT_W-1:0] w_load;
  logic [PTR_W-1:0] w_owner_inc;
  logic             w_owner_live;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req     (req),
    .i_pointer (r_ptr),
    .o_winner  (w_win),
    .o_valid   (w_win_vld)
  );

  always_comb begin
    w_win_idx = '0;
    w_load    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_win_idx = PTR_W'(i);
        w_load    = load_val[i*CNT_W +: CNT_W];
      end
    end
  end

  assign w_owner_inc  = (r_owner == LAST_IDX) ? '0 : r_owner + PTR_W'(1);
  assign w_owner_live = |(req & r_grant);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_grant_nxt = w_win;
          w_owner_nxt = w_win_idx;
          w_cnt_nxt   = w_load;
          if (w_load == '0) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = w_win;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Abort beats a final decrement landing in the same cycle.
        if (!w_owner_live) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = w_owner_inc;
        end else if (enable) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DONE;
            w_done_nxt  = r_grant;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
        w_ptr_nxt   = w_owner_inc;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE);
  assign remaining = r_cnt;

endmodule

// File: tb/tb_shared_timer_scheduler.sv
// Directed scenarios plus randomized traffic for shared_timer_scheduler, checked every cycle
// against a transaction-level reference (owner, count, pointer kept as plain integers).
module tb_shared_timer_scheduler;

  localparam int NR = 4;
  localparam int CW = 27;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [NR-1:0]    req;
  logic [NR*CW-1:0] load_val;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    done;
  logic             busy;
  logic [CW-1:0]    remaining;

  always #5 clk = ~clk;

  shared_timer_scheduler #(
    .NREQ  (NR),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .load_val  (load_val),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .remaining (remaining)
  );

  int total = 0;
  int bad   = 0;

  // Reference: owner index (-1 when idle), count left, completion flag, rotation pointer.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_done  = 1'b0;
  int ld [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ld(input int i, input int v);
    ld[i] = v;
    load_val[i*CW +: CW] = CW'(v);
  endtask

  task automatic model_step();
    if (reset) begin
      m_owner = -1; m_done = 1'b0; m_cnt = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        int c = (m_ptr + k) % NR;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_cnt   = ld[c];
          m_done  = (m_cnt == 0);
        end
      end
    end else if (m_done || !req[m_owner]) begin
      m_ptr = (m_owner + 1) % NR;
      m_owner = -1; m_done = 1'b0; m_cnt = 0;
    end else if (enable) begin
      m_cnt--;
      m_done = (m_cnt == 0);
    end
  endtask

  task automatic check_outputs();
    logic [NR-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    chk("grant", grant, g);
    chk("done", done, m_done ? g : '0);
    chk("busy", busy, m_owner >= 0);
    chk("remaining", remaining, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    bit found;
    int order[$];
    int hold[$];
    int hcnt;
    logic [NR-1:0] prev;
    int exp_rem[6] = '{3, 2, 2, 1, 1, 0};
    bit en_pat[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; enable = 1'b0; req = '0; load_val = '0;
    for (int i = 0; i < NR; i++) set_ld(i, 0);

    // Reset state
    do_reset();
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    step();

    // Single request, delay 5
    req = 4'b0001; set_ld(0, 5); enable = 1'b1;
    n = 0; found = 1'b0;
    while (!found && n < 20) begin
      step(); n++;
      if (done[0]) found = 1'b1;
    end
    chk("single_done_seen", found, 1);
    chk("single_done_latency", n, 6);
    req = '0;
    step();
    chk("single_busy_low", busy, 0);

    // Contention: all requesting, delay 2 each
    do_reset();
    for (int i = 0; i < NR; i++) set_ld(i, 2);
    req = 4'b1111; prev = '0; hcnt = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      step();
      if (grant != 0) begin
        if (prev == 0) begin
          for (int i = 0; i < NR; i++) if (grant[i]) order.push_back(i);
          hcnt = 0;
        end
        hcnt++;
      end else if (prev != 0) begin
        hold.push_back(hcnt);
      end
      prev = grant;
    end
    chk("contention_owner_count", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) chk("contention_order", order[i], i % NR);
    chk("contention_hold_count", hold.size() >= 4, 1);
    for (int i = 0; i < hold.size() && i < 4; i++) chk("contention_grant_cycles", hold[i], 3);
    req = '0;

    // Enable gating
    do_reset();
    req = 4'b0001; set_ld(0, 3); enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("gating_remaining", remaining, exp_rem[k]);
      if (k < 5) enable = en_pat[k];
    end
    chk("gating_done", done, 4'b0001);
    req = '0; enable = 1'b1;
    step();

    // Zero delay
    do_reset();
    req = 4'b0100; set_ld(2, 0);
    step();
    chk("zero_grant", grant, 4'b0100);
    chk("zero_done", done, 4'b0100);
    req = '0;
    step();
    chk("zero_idle_busy", busy, 0);

    // Abort by owner 1 at remaining 6; late request from 2 must wait
    do_reset();
    req = 4'b0010; set_ld(1, 10); set_ld(2, 3);
    step();
    req = 4'b0110;
    n = 0; found = 1'b0;
    while (!found && n < 20) begin
      step(); n++;
      if (remaining == 6) found = 1'b1;
    end
    chk("abort_reached_6", found, 1);
    req = 4'b0100;
    step();
    chk("abort_grant_clear", grant, 0);
    chk("abort_no_done", done, 0);
    step();
    chk("abort_next_owner", grant, 4'b0100);
    req = '0;

    // Reset mid-run at remaining 4
    do_reset();
    req = 4'b0001; set_ld(0, 8);
    n = 0; found = 1'b0;
    while (!found && n < 20) begin
      step(); n++;
      if (remaining == 4) found = 1'b1;
    end
    chk("rst_reached_4", found, 1);
    reset = 1'b1; req = 4'b1010;
    step();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_remaining", remaining, 0);
    reset = 1'b0;
    step();
    chk("rst_winner", grant, 4'b0010);

    // Randomized traffic with live load_val changes and occasional reset
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 4) == 0) req = NR'($urandom_range(0, 15));
      set_ld(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 5)));
      enable = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
